// File: rtl/seg_pattern_reader_if.sv
// Result handshake bundle for seg_pattern_reader: decoded digit, error flag and
// accepted-digit history leave on out_valid/out_ready.
interface seg_pattern_reader_if;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_value;
    logic        out_err;
    logic [15:0] history;

    modport master (
        output out_valid,
        output out_value,
        output out_err,
        output history,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_value,
        input  out_err,
        input  history,
        output out_ready
    );
endinterface

// File: rtl/seg_pattern_reader.sv
// Recovers a hex digit from a deglitched active-low 7-segment pattern and reports it
// once per displayed glyph. Define SEG_HISTORY_EN to keep the last four accepted digits.
module seg_pattern_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            seg_in,
    seg_pattern_reader_if.master  bus
);

    localparam int              CW       = $clog2(STABLE_CYCLES + 1);
    localparam logic [6:0]      BLANK    = 7'h7F;
    localparam logic [CW-1:0]   CNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, WAIT_CHANGE} state_t;

    state_t        state, state_d;
    logic [6:0]    seg_q;
    logic [6:0]    pat, pat_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          valid_q, valid_d;
    logic [3:0]    value_q, value_d;
    logic          err_q, err_d;
    logic          accept;

    // Returns {illegal, digit}; illegal glyphs decode to digit 0.
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = {1'b0, 4'h0};
            7'h79:   r = {1'b0, 4'h1};
            7'h24:   r = {1'b0, 4'h2};
            7'h30:   r = {1'b0, 4'h3};
            7'h19:   r = {1'b0, 4'h4};
            7'h12:   r = {1'b0, 4'h5};
            7'h02:   r = {1'b0, 4'h6};
            7'h78:   r = {1'b0, 4'h7};
            7'h00:   r = {1'b0, 4'h8};
            7'h10:   r = {1'b0, 4'h9};
            7'h08:   r = {1'b0, 4'hA};
            7'h03:   r = {1'b0, 4'hB};
            7'h46:   r = {1'b0, 4'hC};
            7'h21:   r = {1'b0, 4'hD};
            7'h06:   r = {1'b0, 4'hE};
            7'h0E:   r = {1'b0, 4'hF};
            default: r = {1'b1, 4'h0};
        endcase
        return r;
    endfunction

    assign accept = valid_q & bus.out_ready;

    always_comb begin
        // NOTE: every next-state value gets a default first so no path infers a latch.
        state_d = state;
        pat_d   = pat;
        cnt_d   = cnt;
        valid_d = valid_q;
        value_d = value_q;
        err_d   = err_q;
        case (state)
            IDLE: begin
                if (seg_q != BLANK) begin
                    pat_d   = seg_q;
                    cnt_d   = CNT_ONE;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (seg_q == BLANK) begin
                    pat_d   = BLANK;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (seg_q != pat) begin
                    pat_d = seg_q;
                    cnt_d = CNT_ONE;
                end else if (cnt == CNT_MAX) begin
                    {err_d, value_d} = decode(pat);
                    valid_d          = 1'b1;
                    state_d          = PRESENT;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            PRESENT: begin
                // Result is frozen here; segment changes wait for WAIT_CHANGE.
                if (accept) begin
                    valid_d = 1'b0;
                    state_d = WAIT_CHANGE;
                end
            end
            WAIT_CHANGE: begin
                if (seg_q == BLANK) begin
                    pat_d   = BLANK;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (seg_q != pat) begin
                    pat_d   = seg_q;
                    cnt_d   = CNT_ONE;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            seg_q   <= BLANK;
            pat     <= BLANK;
            cnt     <= '0;
            valid_q <= 1'b0;
            value_q <= 4'h0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_d;
            seg_q   <= seg_in;
            pat     <= pat_d;
            cnt     <= cnt_d;
            valid_q <= valid_d;
            value_q <= value_d;
            err_q   <= err_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_value = value_q;
    assign bus.out_err   = err_q;

`ifdef SEG_HISTORY_EN
    logic [15:0] hist;

    // Only legal digits that the consumer actually took enter the history.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist <= 16'h0000;
        end else if (accept && !err_q) begin
            hist <= {hist[11:0], value_q};
        end
    end

    assign bus.history = hist;
`else
    assign bus.history = 16'h0000;
`endif

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Directed bench for seg_pattern_reader: latency, deglitch, illegal glyphs,
// back-pressure, reset in PRESENT and history (SEG_HISTORY_EN aware).
module tb_seg_pattern_reader;

    logic       clock;
    logic       reset;
    logic [6:0] seg_in;
    int         checks;
    int         errors;
    int         pulses;
    logic [15:0] exp_hist;

    seg_pattern_reader_if bus ();

    seg_pattern_reader #(.STABLE_CYCLES(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .seg_in (seg_in),
        .bus    (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Ticks until out_valid is seen, bounded; a timeout is itself a failed check.
    task automatic wait_valid(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (bus.out_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {15'd0, seen}, 16'd1);
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.out_valid === 1'b1) n++;
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_hist      = 16'h0000;
        reset         = 1'b1;
        seg_in        = 7'h7F;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("reset_valid", {15'd0, bus.out_valid}, 16'd0);
        check("reset_value", {12'd0, bus.out_value}, 16'd0);
        check("reset_err",   {15'd0, bus.out_err},   16'd0);
        check("reset_hist",  bus.history,            16'h0000);

        // 1: latency, glyph 24 -> 2, valid first seen after edge 6
        seg_in = 7'h24;
        for (int i = 1; i <= 5; i++) tick();
        check("t1_not_yet", {15'd0, bus.out_valid}, 16'd0);
        tick();
        check("t1_valid_edge6", {15'd0, bus.out_valid}, 16'd1);
        check("t1_value", {12'd0, bus.out_value}, 16'h2);
        check("t1_err",   {15'd0, bus.out_err},   16'd0);
        count_pulses(10, pulses);
        check("t1_one_pulse", 16'(pulses), 16'd0);
`ifdef SEG_HISTORY_EN
        exp_hist = 16'h0002;
`endif
        check("t1_hist", bus.history, exp_hist);

        // 2: glitchy toggling never settles, then 30 held reports 3
        pulses = 0;
        for (int p = 0; p < 10; p++) begin
            seg_in = (p % 2 == 0) ? 7'h79 : 7'h30;
            for (int c = 0; c < 2; c++) begin
                tick();
                if (bus.out_valid === 1'b1) pulses++;
            end
        end
        check("t2_toggle_quiet", 16'(pulses), 16'd0);
        wait_valid("t2_timeout", 12);
        check("t2_value", {12'd0, bus.out_value}, 16'h3);
        check("t2_err",   {15'd0, bus.out_err},   16'd0);
        tick();
        check("t2_accepted", {15'd0, bus.out_valid}, 16'd0);
`ifdef SEG_HISTORY_EN
        exp_hist = 16'h0023;
`endif
        check("t2_hist", bus.history, exp_hist);

        // 3: illegal glyph 55
        seg_in = 7'h55;
        wait_valid("t3_timeout", 12);
        check("t3_err",   {15'd0, bus.out_err},   16'd1);
        check("t3_value", {12'd0, bus.out_value}, 16'h0);
        tick();
        check("t3_hist_unchanged", bus.history, exp_hist);

        // 4: back-pressure holds F while seg_in moves to 40
        bus.out_ready = 1'b0;
        seg_in        = 7'h0E;
        wait_valid("t4_timeout", 12);
        check("t4_value", {12'd0, bus.out_value}, 16'hF);
        seg_in = 7'h40;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.out_valid === 1'b1 && bus.out_value === 4'hF) pulses++;
        end
        check("t4_held", 16'(pulses), 16'd10);
        bus.out_ready = 1'b1;
        tick();
        check("t4_handshake", {15'd0, bus.out_valid}, 16'd0);
`ifdef SEG_HISTORY_EN
        exp_hist = 16'h023F;
`endif
        check("t4_hist_f", bus.history, exp_hist);
        for (int i = 0; i < 4; i++) tick();
        check("t4_40_not_yet", {15'd0, bus.out_valid}, 16'd0);
        tick();
        check("t4_40_valid", {15'd0, bus.out_valid}, 16'd1);
        check("t4_40_value", {12'd0, bus.out_value}, 16'h0);
        tick();

        // 5: reset while in PRESENT clears everything
        bus.out_ready = 1'b0;
        seg_in        = 7'h79;
        wait_valid("t5_timeout", 12);
        check("t5_pre_value", {12'd0, bus.out_value}, 16'h1);
        seg_in = 7'h7F;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        check("t5_valid", {15'd0, bus.out_valid}, 16'd0);
        check("t5_value", {12'd0, bus.out_value}, 16'd0);
        check("t5_err",   {15'd0, bus.out_err},   16'd0);
        check("t5_hist",  bus.history,            16'h0000);
        count_pulses(10, pulses);
        check("t5_blank_quiet", 16'(pulses), 16'd0);

        // 6: accept 1..5 in sequence
        bus.out_ready = 1'b1;
        begin
            logic [6:0] glyphs [5];
            glyphs = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
            for (int d = 0; d < 5; d++) begin
                seg_in = glyphs[d];
                wait_valid("t6_timeout", 12);
                check("t6_value", {12'd0, bus.out_value}, 16'(d + 1));
                tick();
            end
        end
`ifdef SEG_HISTORY_EN
        exp_hist = 16'h2345;
`else
        exp_hist = 16'h0000;
`endif
        check("t6_hist", bus.history, exp_hist);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
